// File: rtl/int_ctrl_if.sv
// -----------------------------------------------------------------------------
// int_ctrl_if -- CPU-side bundle of the interrupt controller.
//   master : drives irq, int_ack, iret, mask_we, mask_in (CPU / system side)
//            and observes int_req, vector, in_service, active_id, pending, mask.
//   slave  : the controller itself (int_ctrl), with the directions reversed.
// Clock and reset are plain ports of the controller and are not carried here.
// -----------------------------------------------------------------------------
interface int_ctrl_if;
  logic [3:0] irq;         // request lines, bit 0 = highest priority
  logic       int_ack;     // CPU took the vector this cycle
  logic       iret;        // CPU returns from the handler this cycle
  logic       mask_we;     // mask register write strobe
  logic [3:0] mask_in;     // new mask value, 1 = line disabled
  logic       int_req;     // request to the CPU sequencer
  logic [9:0] vector;      // handler entry address
  logic       in_service;  // a handler is running
  logic [1:0] active_id;   // line being requested / serviced
  logic [3:0] pending;     // latched pending bits
  logic [3:0] mask;        // current mask register

  modport master (
    output irq, int_ack, iret, mask_we, mask_in,
    input  int_req, vector, in_service, active_id, pending, mask
  );

  modport slave (
    input  irq, int_ack, iret, mask_we, mask_in,
    output int_req, vector, in_service, active_id, pending, mask
  );
endinterface

// File: rtl/int_ctrl.sv
// -----------------------------------------------------------------------------
// int_ctrl -- four-line, fixed-priority, non-nesting interrupt controller.
//   clk    : single clock, all state changes on its rising edge
//   reset  : asynchronous, active-low
//   bus    : int_ctrl_if.slave
//            in : irq[3:0], int_ack, iret, mask_we, mask_in[3:0]
//            out: int_req, vector[9:0], in_service, active_id[1:0],
//                 pending[3:0], mask[3:0]
// Rising edges on irq latch pending bits regardless of mask. From IDLE the
// lowest-index unmasked pending line is chosen and requested (REQ); int_ack
// moves to SERVICE and clears that pending bit; iret returns to IDLE.
// -----------------------------------------------------------------------------
module int_ctrl (
  input  logic        clk,
  input  logic        reset,
  int_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  localparam logic [9:0] VECTOR_BASE = 10'h3C0;

  state_t     state_q, state_d;
  logic [3:0] irq_prev_q;
  logic [3:0] pending_q, pending_d;
  logic [3:0] mask_q, mask_d;
  logic [1:0] active_id_q, active_id_d;

  logic [3:0] rise;
  logic [3:0] eligible;
  logic [1:0] sel_id;

  assign rise     = bus.irq & ~irq_prev_q;
  assign eligible = pending_q & ~mask_q;

  // Fixed priority: scanning from the top down lets the lowest set index win.
  always_comb begin
    sel_id = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (eligible[i]) sel_id = 2'(i);
    end
  end

  // ---------------------------------------------------------------------------
  // State register (with the other sequential state)
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      irq_prev_q  <= 4'b0000;
      pending_q   <= 4'b0000;
      mask_q      <= 4'b1111;
      active_id_q <= 2'd0;
    end else begin
      state_q     <= state_d;
      irq_prev_q  <= bus.irq;
      pending_q   <= pending_d;
      mask_q      <= mask_d;
      active_id_q <= active_id_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    active_id_d = active_id_q;
    pending_d   = pending_q;
    mask_d      = bus.mask_we ? bus.mask_in : mask_q;

    unique case (state_q)
      IDLE: begin
        if (|eligible) begin
          state_d     = REQ;
          active_id_d = sel_id;
        end
      end
      REQ: begin
        // active_id is frozen here; mask writes or new edges cannot cancel.
        if (bus.int_ack) begin
          state_d                 = SERVICE;
          pending_d[active_id_q]  = 1'b0;
        end
      end
      SERVICE: begin
        if (bus.iret) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // New edges are merged after the ack clear, so an edge on the acked line
    // in the same cycle leaves its pending bit set.
    pending_d = pending_d | rise;
  end

  // ---------------------------------------------------------------------------
  // Output logic (Moore)
  // ---------------------------------------------------------------------------
  always_comb begin
    bus.int_req    = (state_q == REQ);
    bus.in_service = (state_q == SERVICE);
    bus.active_id  = active_id_q;
    bus.vector     = VECTOR_BASE + {6'd0, active_id_q, 2'b00};
    bus.pending    = pending_q;
    bus.mask       = mask_q;
  end

endmodule

// File: tb/tb_int_ctrl.sv
// -----------------------------------------------------------------------------
// tb_int_ctrl -- directed bench for int_ctrl. Expected interrupt ids are queued
// when the irq stimulus is driven and popped when the controller raises
// int_req; direct checks cover latency, pending/mask state and reset.
// -----------------------------------------------------------------------------
module tb_int_ctrl;

  logic clk = 1'b0;
  logic reset;

  int_ctrl_if bus ();

  int_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  int unsigned exp_q[$];
  logic [9:0]  vec_tab [4] = '{10'h3C0, 10'h3C4, 10'h3C8, 10'h3CC};

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Advance one rising edge, then settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_mask(input logic [3:0] m);
    bus.mask_we = 1'b1;
    bus.mask_in = m;
    tick();
    bus.mask_we = 1'b0;
  endtask

  // Wait (bounded) for a request, then compare against the scoreboard head.
  task automatic wait_req(input string tag);
    int n;
    int unsigned id;
    n = 0;
    while (!bus.int_req && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_req_seen"}, 32'(bus.int_req), 32'd1);
    if (bus.int_req) begin
      if (exp_q.size() == 0) begin
        check({tag, "_unexpected_req"}, 32'd1, 32'd0);
      end else begin
        id = exp_q.pop_front();
        check({tag, "_id"},     32'(bus.active_id), id);
        check({tag, "_vector"}, 32'(bus.vector),    32'(vec_tab[id]));
      end
    end
  endtask

  task automatic ack_and_ret(input string tag);
    bus.int_ack = 1'b1;
    tick();
    bus.int_ack = 1'b0;
    check({tag, "_in_service"}, 32'(bus.in_service), 32'd1);
    check({tag, "_req_dropped"}, 32'(bus.int_req), 32'd0);
    tick();
    bus.iret = 1'b1;
    tick();
    bus.iret = 1'b0;
    check({tag, "_idle"}, 32'(bus.in_service), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset       = 1'b0;
    bus.irq     = 4'b0000;
    bus.int_ack = 1'b0;
    bus.iret    = 1'b0;
    bus.mask_we = 1'b0;
    bus.mask_in = 4'b0000;
    tick();
    tick();
    reset = 1'b1;

    // Reset state
    check("rst_pending",    32'(bus.pending),    32'h0);
    check("rst_mask",       32'(bus.mask),       32'hF);
    check("rst_int_req",    32'(bus.int_req),    32'd0);
    check("rst_in_service", 32'(bus.in_service), 32'd0);
    check("rst_active_id",  32'(bus.active_id),  32'd0);
    check("rst_vector",     32'(bus.vector),     32'h3C0);

    // Scenario 1: single line 2, one-cycle latency, ack/iret
    set_mask(4'b0000);
    bus.irq = 4'b0100;
    tick();
    bus.irq = 4'b0000;
    exp_q.push_back(2);
    check("s1_pending",     32'(bus.pending), 32'h4);
    check("s1_no_req_yet",  32'(bus.int_req), 32'd0);
    tick();
    check("s1_latency",     32'(bus.int_req), 32'd1);
    wait_req("s1");
    bus.iret = 1'b1;            // iret outside SERVICE is ignored
    tick();
    bus.iret = 1'b0;
    check("s1_iret_ignored", 32'(bus.int_req), 32'd1);
    bus.int_ack = 1'b1;
    tick();
    bus.int_ack = 1'b0;
    check("s1_ack_pending", 32'(bus.pending),    32'h0);
    check("s1_ack_service", 32'(bus.in_service), 32'd1);
    bus.int_ack = 1'b1;         // int_ack outside REQ is ignored
    tick();
    bus.int_ack = 1'b0;
    check("s1_ack_ignored", 32'(bus.in_service), 32'd1);
    bus.iret = 1'b1;
    tick();
    bus.iret = 1'b0;
    check("s1_iret_idle",   32'(bus.in_service), 32'd0);
    tick();
    check("s1_stays_idle",  32'(bus.int_req),    32'd0);

    // Scenario 2: simultaneous lines 1 and 3
    bus.irq = 4'b1010;
    tick();
    bus.irq = 4'b0000;
    exp_q.push_back(1);
    exp_q.push_back(3);
    tick();
    wait_req("s2a");
    bus.int_ack = 1'b1;
    tick();
    bus.int_ack = 1'b0;
    check("s2_pending_left", 32'(bus.pending), 32'h8);
    bus.iret = 1'b1;
    tick();
    bus.iret = 1'b0;
    check("s2_idle_cycle",  32'(bus.int_req), 32'd0);
    tick();
    check("s2_second_req",  32'(bus.int_req), 32'd1);
    wait_req("s2b");
    ack_and_ret("s2b");

    // Scenario 3: masked pending becomes eligible once unmasked
    set_mask(4'b0001);
    bus.irq = 4'b0001;
    tick();
    bus.irq = 4'b0000;
    check("s3_pending_masked", 32'(bus.pending), 32'h1);
    tick();
    tick();
    check("s3_masked_no_req",  32'(bus.int_req), 32'd0);
    exp_q.push_back(0);
    set_mask(4'b0000);
    check("s3_unmask_edge",    32'(bus.int_req), 32'd0);
    tick();
    check("s3_unmask_req",     32'(bus.int_req), 32'd1);
    wait_req("s3");
    ack_and_ret("s3");

    // Scenario 4: higher-priority arrival and mask write during REQ
    bus.irq = 4'b0100;
    tick();
    bus.irq = 4'b0000;
    exp_q.push_back(2);
    tick();
    wait_req("s4a");
    bus.irq = 4'b0001;
    tick();
    bus.irq = 4'b0000;
    check("s4_pending_both",  32'(bus.pending),   32'h5);
    check("s4_id_frozen",     32'(bus.active_id), 32'd2);
    set_mask(4'b0100);
    check("s4_mask_no_cancel", 32'(bus.int_req),  32'd1);
    check("s4_mask_id_frozen", 32'(bus.active_id), 32'd2);
    set_mask(4'b0000);
    exp_q.push_back(0);
    ack_and_ret("s4a");
    wait_req("s4b");
    ack_and_ret("s4b");

    // Scenario 5: edge on the acked line coincides with int_ack
    bus.irq = 4'b0010;
    tick();
    bus.irq = 4'b0000;
    exp_q.push_back(1);
    tick();
    wait_req("s5a");
    bus.int_ack = 1'b1;
    bus.irq     = 4'b0010;
    tick();
    bus.int_ack = 1'b0;
    bus.irq     = 4'b0000;
    check("s5_pending_kept", 32'(bus.pending),    32'h2);
    check("s5_service",      32'(bus.in_service), 32'd1);
    exp_q.push_back(1);
    bus.iret = 1'b1;
    tick();
    bus.iret = 1'b0;
    check("s5_idle_cycle",   32'(bus.int_req),    32'd0);
    wait_req("s5b");
    ack_and_ret("s5b");

    // Scenario 6: asynchronous reset during SERVICE
    bus.irq = 4'b0001;
    tick();
    bus.irq = 4'b0000;
    exp_q.push_back(0);
    tick();
    wait_req("s6");
    bus.irq     = 4'b1000;
    bus.int_ack = 1'b1;
    tick();
    bus.int_ack = 1'b0;
    bus.irq     = 4'b0000;
    check("s6_pre_service", 32'(bus.in_service), 32'd1);
    check("s6_pre_pending", 32'(bus.pending),    32'h8);
    #2;
    reset = 1'b0;
    #1;
    check("s6_async_service", 32'(bus.in_service), 32'd0);
    check("s6_async_req",     32'(bus.int_req),    32'd0);
    check("s6_async_pending", 32'(bus.pending),    32'h0);
    check("s6_async_mask",    32'(bus.mask),       32'hF);
    check("s6_async_vector",  32'(bus.vector),     32'h3C0);

    // Line already high at reset release counts as a rising edge
    bus.irq = 4'b0100;
    tick();
    reset = 1'b1;
    tick();
    check("rel_edge_pending", 32'(bus.pending), 32'h4);
    check("rel_masked_idle",  32'(bus.int_req), 32'd0);
    bus.irq = 4'b0000;
    tick();

    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/int_ctrl.md
INT_CTRL -- requirements
Module: int_ctrl

Interface
REQ-001 The block SHALL have these ports (name, direction, width, meaning), clock and reset first:
- clk  in  1  single clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low; 0 forces the reset state immediately.
- irq  in  4  interrupt request lines, synchronous to clk; bit 0 is the highest priority.
- int_ack  in  1  CPU has taken the vector and pushed the return PC this cycle.
- iret  in  1  CPU executes return-from-interrupt this cycle.
- mask_we  in  1  write strobe for the mask register.
- mask_in  in  4  new mask value; 1 = line disabled.
- int_req  out  1  interrupt request to the CPU sequencer.
- vector  out  10  jump target for the accepted interrupt.
- in_service  out  1  a handler is running.
- active_id  out  2  index of the requested or serviced line.
- pending  out  4  latched pending bits.
- mask  out  4  current mask register.
REQ-002 The block SHALL use one clock (clk) and an asynchronous, active-low reset (reset).

Function
REQ-003 The block SHALL register irq into irq_prev every cycle. A rising edge on line i is irq[i]=1 while irq_prev[i]=0.
REQ-004 A rising edge on line i SHALL set pending[i] at that clock edge, regardless of mask.
REQ-005 Any change on irq other than a rising edge SHALL NOT alter pending.
REQ-006 When mask_we=1, mask SHALL load mask_in at the clock edge.
REQ-007 The FSM SHALL have exactly three states: IDLE, REQ and SERVICE.
REQ-008 In IDLE, if (pending & ~mask) is nonzero, the block SHALL latch active_id as the lowest set index and go to REQ at the next edge.
REQ-009 In REQ, the block SHALL go to SERVICE and clear pending[active_id] when int_ack=1.
REQ-010 In SERVICE, the block SHALL go to IDLE when iret=1.
REQ-011 int_req SHALL equal 1 only when the state is REQ, and in_service SHALL equal 1 only when the state is SERVICE. Both are Moore outputs.
REQ-012 vector SHALL equal 0x3C0 + 4*active_id, giving 0x3C0, 0x3C4, 0x3C8 or 0x3CC.
REQ-013 Latency: a rising edge sampled at edge k SHALL make int_req high after edge k+1, provided the state was IDLE and the line is unmasked.
REQ-014 Once in REQ, active_id SHALL stay frozen. A higher-priority arrival or a mask write SHALL NOT cancel or change the current request.
REQ-015 There SHALL be no nesting: new pending bits only accumulate during REQ and SERVICE.
REQ-016 int_ack outside REQ and iret outside SERVICE SHALL be ignored.
REQ-017 If a rising edge on line active_id coincides with the clearing int_ack, pending[active_id] SHALL remain 1.
REQ-018 On return to IDLE with unmasked pending bits, the next request SHALL be issued after one cycle in IDLE.
REQ-019 Masked pending bits SHALL be retained and SHALL become eligible as soon as they are unmasked.
REQ-020 Priority selection SHALL be fixed and combinational over (pending & ~mask), with index 0 highest.

Reset
REQ-021 While reset=0, the block SHALL hold: state=IDLE, pending=0, mask=4'b1111 (all masked), irq_prev=0, active_id=0, int_req=0, in_service=0, vector=0x3C0.
REQ-022 Reset asserted mid-REQ or mid-SERVICE SHALL abort immediately to the reset values, and pending requests SHALL be lost.
REQ-023 After reset release, a line already high SHALL count as a rising edge on the first edge, because irq_prev=0.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- Reset, mask<=0, pulse irq[2] at edge 5: pending=4'b0100 after edge 5; int_req=1, active_id=2, vector=0x3C8 after edge 6; int_ack at edge 8 gives pending=0 and in_service=1; iret at edge 10 gives IDLE.
- irq=4'b1010 rising together, mask=0: serve id 1 first (vector 0x3C4); after iret, one IDLE cycle, then id 3 (vector 0x3CC).
- mask=4'b0001, irq[0] edge: pending[0]=1, int_req stays 0; write mask=0: int_req=1 two edges later with vector 0x3C0.
- In REQ for id 2, irq[0] edge: active_id stays 2 until int_ack; id 0 is served after iret.
- irq[1] rising on the same edge as int_ack for id 1: pending[1] remains 1; a new request for id 1 follows the iret.
- reset=0 asynchronously during SERVICE: in_service, int_req and pending go to 0 and mask to 4'b1111 without waiting for a clock edge.
